// File: rtl/udivider_seq.sv
// Iterative unsigned restoring divider: one shift-and-trial-subtract per clock,
// start/busy/done handshake, quotient/remainder held until the next completion.
module udivider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | iterating, one quotient bit per clock
  // DONE  | done pulse cycle, results valid; start accepted here too
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // R < D after every iteration, so the partial remainder's top bit is always
  // zero and only the WIDTH low bits are stored.
  always_comb begin
    rs     = {r_reg, q_reg[WIDTH-1]};
    t      = rs - {1'b0, d_reg};
    q_next = {q_reg[WIDTH-2:0], 1'b0};
    r_next = rs[WIDTH-1:0];
    if (!t[WIDTH]) begin
      q_next = {q_reg[WIDTH-2:0], 1'b1};
      r_next = t[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
